monte_carlo_stat_array: RTL and testbench
=========================================

MONTE_CARLO_STAT_ARRAY -- requirements
Module: monte_carlo_stat_array

Interface
REQ-001 Parameter NUM_LANES, default 4: number of game-engine lanes run in parallel (1..16).
REQ-002 Parameter MOVE_W, default 15: width of each lane's move count.
REQ-003 Parameter TOTAL_W, default 32: width of the total move accumulator.
REQ-004 Parameter TRIAL_W, default 32: width of the trial budget and trial counter.
REQ-005 The block SHALL have the following ports.
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- start, input, 1: pulse that begins a run.
- trial_budget, input, TRIAL_W: trials to execute, sampled on the accepted start.
- lane_rst, output, NUM_LANES: per-lane engine reset.
- rnd_rst, output, 1: shared random generator reset.
- lane_stuck, input, NUM_LANES: per-lane game-over flag.
- lane_move_count, input, NUM_LANES*MOVE_W: lane i occupies bits [i*MOVE_W +: MOVE_W].
- busy, output, 1: a run is in progress.
- done, output, 1: one-cycle pulse at the end of a run.
- max_move_count, output, MOVE_W: largest per-trial move count.
- total_move_count, output, TOTAL_W: sum of per-trial move counts.
- total_trial_count, output, TRIAL_W: trials completed.
- min_move_count, output, MOVE_W: smallest per-trial move count (MCSTAT_MIN_EN only).

Function
REQ-006 Top FSM states SHALL be IDLE, RUN, FINISH.
- IDLE->RUN on start; this clears all statistics and latches trial_budget.
- RUN->FINISH when issued == budget, all lanes are IDLE and no collection is pending.
- FINISH->IDLE after one cycle, with done=1 in that FINISH cycle.
REQ-007 start while busy SHALL be ignored; busy SHALL be 1 in RUN and FINISH.
REQ-008 Each lane FSM SHALL be L_IDLE, L_RST, L_RUN, L_COLLECT.
- L_IDLE->L_RST when the top FSM is in RUN and issued < budget; this increments issued.
- Lowest idle lane index wins when several lanes could launch; at most one launch per cycle.
REQ-009 lane_rst[i] SHALL be 1 exactly during L_RST (one cycle); then the lane goes L_RST->L_RUN.
REQ-010 lane_stuck[i] SHALL be sampled only in L_RUN; stuck=1 moves the lane to L_COLLECT.
REQ-011 The collector SHALL accept one L_COLLECT lane per cycle, round-robin starting after the last accepted lane.
- The accepted lane's move count is registered into the statistics the same edge.
- The accepted lane returns to L_IDLE.
- Non-accepted lanes hold L_COLLECT.
REQ-012 Per accepted trial:
- total_move_count += zero-extended move count, saturating at all-ones.
- total_trial_count += 1.
- max_move_count updates if the move count is strictly greater.
REQ-013 trial_budget=0 SHALL give RUN->FINISH on the cycle after start, with all statistics 0 and no lane_rst pulses.
REQ-014 rnd_rst SHALL be 1 from reset until the first accepted start, then 0 for all subsequent cycles.
REQ-015 Statistics outputs SHALL hold their values after done until the next accepted start.

Reset
REQ-016 rst SHALL force:
- top FSM to IDLE and all lanes to L_IDLE;
- lane_rst=0, rnd_rst=1, busy=0, done=0;
- all statistics to 0, min_move_count to all-ones;
- issued counter and round-robin pointer to 0.
REQ-017 rst asserted mid-run SHALL abandon the run without asserting done.

Configuration
REQ-018 With MCSTAT_MIN_EN defined:
- min_move_count SHALL exist;
- it resets and clears on start to all-ones;
- it updates when an accepted move count is strictly smaller.
REQ-019 Without MCSTAT_MIN_EN, the min_move_count port and its logic SHALL be absent.

Structure
REQ-020 Package mcstat_pkg SHALL hold the top and lane state enums and the default width constants.
REQ-021 The per-lane FSM SHALL be sub-module mcstat_lane, instantiated NUM_LANES times via generate.

Verification
REQ-022 The bench SHALL cover these directed scenarios (NUM_LANES=4 unless stated).
- Budget 0 -> done one cycle after start; total_trial_count=0, total_move_count=0, max_move_count=0.
- Budget 1 with the lane stuck at move count 37 -> one lane_rst pulse; totals 37/1; max 37; min 37 when MCSTAT_MIN_EN is defined.
- Budget 8 with counts 5, 9, 3, 9, 12, 1, 7, 2 -> total 48, trials 8, max 12, min 1, exactly 8 lane_rst pulses.
- All 4 lanes stuck on the same cycle -> accepted over 4 consecutive cycles in round-robin order; totals correct.
- TOTAL_W=16 with 3 trials of 30000 -> total_move_count saturates at 65535.
- rst mid-run, then start with budget 2 and counts 4, 6 -> no done from the aborted run; new run gives totals 10/2.

Source files
------------

// File: rtl/monte_carlo_stat_array_pkg.sv
// ---------------------------------------------------------------------------
// mcstat_pkg
// Purpose : shared types and default widths for the Monte-Carlo statistics
//           array (top controller, per-lane engine sequencer, bus interface).
// Contents: default parameter constants, top and lane FSM state enums.
// ---------------------------------------------------------------------------
package mcstat_pkg;

  localparam int NUM_LANES_DEF = 4;
  localparam int MOVE_W_DEF    = 15;
  localparam int TOTAL_W_DEF   = 32;
  localparam int TRIAL_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } top_state_t;

  typedef enum logic [1:0] {
    L_IDLE    = 2'd0,
    L_RST     = 2'd1,
    L_RUN     = 2'd2,
    L_COLLECT = 2'd3
  } lane_state_t;

endpackage

// File: rtl/monte_carlo_stat_array_if.sv
// ---------------------------------------------------------------------------
// monte_carlo_stat_array_if
// Purpose : bundles the run-control, lane-engine and statistics signals of
//           monte_carlo_stat_array.
// Modports: master - run requester / lane engines (drives start, budget,
//                    lane_stuck, lane_move_count)
//           slave  - the statistics array itself
// Option  : MCSTAT_MIN_EN adds min_move_count.
// ---------------------------------------------------------------------------
interface monte_carlo_stat_array_if
  import mcstat_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int MOVE_W    = MOVE_W_DEF,
  parameter int TOTAL_W   = TOTAL_W_DEF,
  parameter int TRIAL_W   = TRIAL_W_DEF
);

  logic                        start;
  logic [TRIAL_W-1:0]          trial_budget;
  logic [NUM_LANES-1:0]        lane_rst;
  logic                        rnd_rst;
  logic [NUM_LANES-1:0]        lane_stuck;
  logic [NUM_LANES*MOVE_W-1:0] lane_move_count;
  logic                        busy;
  logic                        done;
  logic [MOVE_W-1:0]           max_move_count;
  logic [TOTAL_W-1:0]          total_move_count;
  logic [TRIAL_W-1:0]          total_trial_count;
`ifdef MCSTAT_MIN_EN
  logic [MOVE_W-1:0]           min_move_count;
`endif

  modport master (
    output start, trial_budget, lane_stuck, lane_move_count,
`ifdef MCSTAT_MIN_EN
    input  min_move_count,
`endif
    input  lane_rst, rnd_rst, busy, done, max_move_count, total_move_count,
           total_trial_count
  );

  modport slave (
    input  start, trial_budget, lane_stuck, lane_move_count,
`ifdef MCSTAT_MIN_EN
    output min_move_count,
`endif
    output lane_rst, rnd_rst, busy, done, max_move_count, total_move_count,
           total_trial_count
  );

endinterface

// File: rtl/monte_carlo_stat_array_lane.sv
// ---------------------------------------------------------------------------
// mcstat_lane
// Purpose : sequences one game-engine lane through reset, play and result
//           collection.
// Ports   : clk, rst (sync, active-high)
//           i_launch   - controller grants a new trial to this lane
//           i_stuck    - engine game-over flag (only looked at while playing)
//           i_accept   - collector took this lane's result
//           o_lane_rst - engine reset, high for the single L_RST cycle
//           o_idle     - lane free for a new trial
//           o_collect  - lane holds a finished result
//
// state     | meaning
// L_IDLE    | free, waiting for a launch
// L_RST     | engine held in reset for one cycle
// L_RUN     | engine playing, watching lane_stuck
// L_COLLECT | result waiting for the round-robin collector
// ---------------------------------------------------------------------------
module mcstat_lane
  import mcstat_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_launch,
  input  logic i_stuck,
  input  logic i_accept,
  output logic o_lane_rst,
  output logic o_idle,
  output logic o_collect
);

  lane_state_t r_state;
  lane_state_t w_state_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= L_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_lane_rst  = 1'b0;
    o_idle      = 1'b0;
    o_collect   = 1'b0;
    case (r_state)
      L_IDLE: begin
        o_idle = 1'b1;
        if (i_launch) w_state_nxt = L_RST;
      end
      L_RST: begin
        o_lane_rst  = 1'b1;
        w_state_nxt = L_RUN;
      end
      L_RUN: begin
        if (i_stuck) w_state_nxt = L_COLLECT;
      end
      L_COLLECT: begin
        o_collect = 1'b1;
        if (i_accept) w_state_nxt = L_IDLE;
      end
      default: w_state_nxt = L_IDLE;
    endcase
  end

endmodule

// File: rtl/monte_carlo_stat_array.sv
// ---------------------------------------------------------------------------
// monte_carlo_stat_array
// Purpose : runs a budget of Monte-Carlo game trials over NUM_LANES parallel
//           engines and accumulates total/max (optionally min) move counts.
// Ports   : clk, rst (sync, active-high)
//           bus (slave) - start/trial_budget, lane_rst/rnd_rst,
//                         lane_stuck/lane_move_count, busy/done, statistics
// Option  : define MCSTAT_MIN_EN to build min_move_count tracking.
//
// state  | meaning
// IDLE   | waiting for start, statistics held
// RUN    | launching trials and collecting results
// FINISH | single cycle, done pulse
// ---------------------------------------------------------------------------
module monte_carlo_stat_array
  import mcstat_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int MOVE_W    = MOVE_W_DEF,
  parameter int TOTAL_W   = TOTAL_W_DEF,
  parameter int TRIAL_W   = TRIAL_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  monte_carlo_stat_array_if.slave  bus
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  top_state_t r_state;
  top_state_t w_state_nxt;

  logic [TRIAL_W-1:0]   r_budget;
  logic [TRIAL_W-1:0]   r_issued;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic                 r_rnd_rst;
  logic [MOVE_W-1:0]    r_max;
  logic [TOTAL_W-1:0]   r_total;
  logic [TRIAL_W-1:0]   r_trials;
`ifdef MCSTAT_MIN_EN
  logic [MOVE_W-1:0]    r_min;
`endif

  logic [NUM_LANES-1:0] w_idle;
  logic [NUM_LANES-1:0] w_collect;
  logic [NUM_LANES-1:0] w_launch;
  logic [NUM_LANES-1:0] w_accept;
  logic [NUM_LANES-1:0] w_lane_rst;
  logic                 w_start_acc;
  logic                 w_can_launch;
  logic                 w_acc_vld;
  logic [IDX_W-1:0]     w_acc_idx;
  logic [MOVE_W-1:0]    w_acc_cnt;
  logic [TOTAL_W:0]     w_sum;

  assign w_start_acc  = (r_state == IDLE) && bus.start;
  assign w_can_launch = (r_state == RUN) && (r_issued < r_budget);

  // One launch per cycle, lowest idle lane first.
  always_comb begin : p_launch
    logic found;
    found    = 1'b0;
    w_launch = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_can_launch && !found && w_idle[i]) begin
        w_launch[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Round-robin collector: search begins just after the last accepted lane.
  always_comb begin : p_collect
    int j;
    j         = 0;
    w_acc_vld = 1'b0;
    w_acc_idx = '0;
    w_accept  = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_LANES) j = j - NUM_LANES;
      if (!w_acc_vld && w_collect[j]) begin
        w_acc_vld = 1'b1;
        w_acc_idx = IDX_W'(j);
      end
    end
    if (w_acc_vld) w_accept[w_acc_idx] = 1'b1;
  end

  assign w_acc_cnt = bus.lane_move_count[w_acc_idx*MOVE_W +: MOVE_W];
  // One extra bit catches the carry that triggers saturation.
  assign w_sum     = {1'b0, r_total} + (TOTAL_W+1)'(w_acc_cnt);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // All lanes idle also means nothing is left waiting in L_COLLECT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if ((r_issued == r_budget) && (&w_idle)) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_budget  <= '0;
      r_issued  <= '0;
      r_rr_ptr  <= '0;
      r_rnd_rst <= 1'b1;
      r_max     <= '0;
      r_total   <= '0;
      r_trials  <= '0;
`ifdef MCSTAT_MIN_EN
      r_min     <= '1;
`endif
    end else if (w_start_acc) begin
      r_budget  <= bus.trial_budget;
      r_issued  <= '0;
      r_rnd_rst <= 1'b0;
      r_max     <= '0;
      r_total   <= '0;
      r_trials  <= '0;
`ifdef MCSTAT_MIN_EN
      r_min     <= '1;
`endif
    end else begin
      if (|w_launch) r_issued <= r_issued + 1'b1;
      if (w_acc_vld) begin
        r_rr_ptr <= w_acc_idx;
        r_total  <= w_sum[TOTAL_W] ? '1 : w_sum[TOTAL_W-1:0];
        r_trials <= r_trials + 1'b1;
        if (w_acc_cnt > r_max) r_max <= w_acc_cnt;
`ifdef MCSTAT_MIN_EN
        if (w_acc_cnt < r_min) r_min <= w_acc_cnt;
`endif
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mcstat_lane u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_launch   (w_launch[g]),
      .i_stuck    (bus.lane_stuck[g]),
      .i_accept   (w_accept[g]),
      .o_lane_rst (w_lane_rst[g]),
      .o_idle     (w_idle[g]),
      .o_collect  (w_collect[g])
    );
  end

  assign bus.lane_rst          = w_lane_rst;
  assign bus.rnd_rst           = r_rnd_rst;
  assign bus.busy              = (r_state != IDLE);
  assign bus.done              = (r_state == FINISH);
  assign bus.max_move_count    = r_max;
  assign bus.total_move_count  = r_total;
  assign bus.total_trial_count = r_trials;
`ifdef MCSTAT_MIN_EN
  assign bus.min_move_count    = r_min;
`endif

endmodule

// File: tb/tb_monte_carlo_stat_array.sv
// ---------------------------------------------------------------------------
// tb_monte_carlo_stat_array
// Purpose : self-checking bench for monte_carlo_stat_array (NUM_LANES=4,
//           plus a TOTAL_W=16 instance for saturation). Lane engines are
//           modelled behaviourally: each lane_rst pulse takes the next move
//           count and delay from queues, then raises lane_stuck.
// Option  : MCSTAT_MIN_EN enables min_move_count checks.
// ---------------------------------------------------------------------------
module tb_monte_carlo_stat_array;

  localparam int NL = 4;
  localparam int MW = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  monte_carlo_stat_array_if #(.NUM_LANES(NL), .MOVE_W(MW), .TOTAL_W(32), .TRIAL_W(32)) bus ();
  monte_carlo_stat_array_if #(.NUM_LANES(NL), .MOVE_W(MW), .TOTAL_W(16), .TRIAL_W(32)) bus16 ();

  monte_carlo_stat_array #(.NUM_LANES(NL), .MOVE_W(MW), .TOTAL_W(32), .TRIAL_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  monte_carlo_stat_array #(.NUM_LANES(NL), .MOVE_W(MW), .TOTAL_W(16), .TRIAL_W(32)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- lane engine model ----------------
  int          cnt_q[$];
  int          dly_q[$];
  logic [MW-1:0] eng_cnt [NL];
  int          eng_dly   [NL];
  bit          eng_armed [NL];
  bit          eng_hold = 1'b0;   // hold all results, release them together
  int          pulses   = 0;

  always @(negedge clk) begin
    bit all_armed;
    all_armed = 1'b1;
    for (int i = 0; i < NL; i++) if (!eng_armed[i]) all_armed = 1'b0;
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        bus.lane_stuck[i] = 1'b0;
        eng_armed[i]      = 1'b0;
        eng_cnt[i]        = '0;
        eng_dly[i]        = 0;
      end
    end else begin
      if (eng_hold && all_armed) begin
        for (int i = 0; i < NL; i++) begin
          bus.lane_stuck[i] = 1'b1;
          eng_armed[i]      = 1'b0;
        end
      end
      for (int i = 0; i < NL; i++) begin
        if (bus.lane_rst[i]) begin
          pulses++;
          bus.lane_stuck[i] = 1'b0;
          eng_cnt[i] = (cnt_q.size() > 0) ? MW'(cnt_q.pop_front()) : '0;
          eng_dly[i] = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
          eng_armed[i] = 1'b1;
        end else if (eng_armed[i] && !eng_hold) begin
          if (eng_dly[i] == 0) begin
            bus.lane_stuck[i] = 1'b1;
            eng_armed[i]      = 1'b0;
          end else begin
            eng_dly[i]--;
          end
        end
      end
    end
  end

  always_comb begin
    bus.lane_move_count = '0;
    for (int i = 0; i < NL; i++) bus.lane_move_count[i*MW +: MW] = eng_cnt[i];
  end

  // ---------------- run helpers ----------------
  task automatic do_run(input int b, input bit poke_busy, output int lat, output int npulse);
    int p0;
    bit got;
    p0 = pulses;
    bus.trial_budget = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_in_run", bus.busy, 1);
    chk("rnd_rst_after_start", bus.rnd_rst, 0);
    if (poke_busy) begin
      @(negedge clk);
      bus.trial_budget = b + 5;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    lat = 0;
    got = 1'b0;
    while (lat < 400 && !got) begin
      @(negedge clk);
      lat++;
      got = bus.done;
    end
    chk("done_seen", got, 1);
    npulse = pulses - p0;
  endtask

  task automatic chk_stats(input int e_total, input int e_trials, input int e_max, input int e_min);
    chk("total_move_count", bus.total_move_count, e_total);
    chk("total_trial_count", bus.total_trial_count, e_trials);
    chk("max_move_count", bus.max_move_count, e_max);
`ifdef MCSTAT_MIN_EN
    chk("min_move_count", bus.min_move_count, e_min);
`endif
  endtask

  typedef struct {
    int budget;
    int cnt [8];
    int e_total;
    int e_trials;
    int e_max;
    int e_min;
  } row_t;

  row_t tbl [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, np, trace[$], f, held;
    bus.start = 1'b0;
    bus.trial_budget = '0;
    bus16.start = 1'b0;
    bus16.trial_budget = '0;
    bus16.lane_stuck = '1;
    bus16.lane_move_count = {NL{15'd30000}};

    tbl[0].budget = 0; tbl[0].cnt = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[0].e_total = 0;     tbl[0].e_trials = 0; tbl[0].e_max = 0;     tbl[0].e_min = 32767;
    tbl[1].budget = 1; tbl[1].cnt = '{37, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].e_total = 37;    tbl[1].e_trials = 1; tbl[1].e_max = 37;    tbl[1].e_min = 37;
    tbl[2].budget = 8; tbl[2].cnt = '{5, 9, 3, 9, 12, 1, 7, 2};
    tbl[2].e_total = 48;    tbl[2].e_trials = 8; tbl[2].e_max = 12;    tbl[2].e_min = 1;
    tbl[3].budget = 3; tbl[3].cnt = '{0, 32767, 100, 0, 0, 0, 0, 0};
    tbl[3].e_total = 32867; tbl[3].e_trials = 3; tbl[3].e_max = 32767; tbl[3].e_min = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rnd_rst", bus.rnd_rst, 1);
    chk("rst_lane_rst", bus.lane_rst, 0);
    chk_stats(0, 0, 0, 32767);
    rst = 1'b0;
    @(negedge clk);
    chk("rnd_rst_before_start", bus.rnd_rst, 1);

    // all four lanes stuck together: acceptance order 1,2,3,0 after reset
    eng_hold = 1'b1;
    cnt_q = '{1, 10, 100, 1000};
    bus.trial_budget = 4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    f = 0;
    while (f < 200 && !bus.done) begin
      @(negedge clk);
      trace.push_back(int'(bus.total_move_count));
      f++;
    end
    chk("rr_done_seen", bus.done, 1);
    f = -1;
    for (int i = 0; i < trace.size(); i++) if (f < 0 && trace[i] != 0) f = i;
    if (f < 0 || f + 3 >= trace.size()) chk("rr_sequence_found", 0, 1);
    else begin
      chk("rr_first_lane1", trace[f], 10);
      chk("rr_second_lane2", trace[f+1], 110);
      chk("rr_third_lane3", trace[f+2], 1110);
      chk("rr_fourth_lane0", trace[f+3], 1111);
    end
    chk("rr_trials", bus.total_trial_count, 4);
    eng_hold = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven runs
    for (int r = 0; r < 4; r++) begin
      cnt_q.delete();
      dly_q.delete();
      for (int i = 0; i < tbl[r].budget; i++) begin
        cnt_q.push_back(tbl[r].cnt[i]);
        dly_q.push_back((r * 3 + i) % 5);
      end
      do_run(tbl[r].budget, (r == 2), lat, np);
      chk_stats(tbl[r].e_total, tbl[r].e_trials, tbl[r].e_max, tbl[r].e_min);
      chk("lane_rst_pulses", np, tbl[r].budget);
      if (tbl[r].budget == 0) chk("budget0_latency", lat, 1);
      repeat (3) @(negedge clk);
      chk("hold_after_done", bus.total_move_count, tbl[r].e_total);
      chk("done_one_cycle", bus.done, 0);
    end

    // randomized runs against an order-independent model
    for (int r = 0; r < 6; r++) begin
      int b, s, mx, mn, c;
      b = $urandom_range(1, 12);
      s = 0; mx = 0; mn = 32767;
      cnt_q.delete();
      dly_q.delete();
      for (int i = 0; i < b; i++) begin
        c = $urandom_range(0, 32767);
        cnt_q.push_back(c);
        dly_q.push_back($urandom_range(0, 7));
        s += c;
        if (c > mx) mx = c;
        if (c < mn) mn = c;
      end
      do_run(b, 1'b0, lat, np);
      chk_stats(s, b, mx, mn);
      chk("rand_lane_rst_pulses", np, b);
      @(negedge clk);
    end

    // saturation on the 16-bit accumulator instance
    bus16.trial_budget = 3;
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    f = 0;
    while (f < 200 && !bus16.done) begin
      @(negedge clk);
      f++;
    end
    chk("sat_done_seen", bus16.done, 1);
    chk("sat_total", bus16.total_move_count, 65535);
    chk("sat_trials", bus16.total_trial_count, 3);
    chk("sat_max", bus16.max_move_count, 30000);
`ifdef MCSTAT_MIN_EN
    chk("sat_min", bus16.min_move_count, 30000);
`endif

    // reset mid-run, then a clean run
    cnt_q = '{11, 12, 13, 14, 15, 16, 17, 18};
    dly_q = '{10, 10, 10, 10, 10, 10, 10, 10};
    bus.trial_budget = 8;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_rnd_rst", bus.rnd_rst, 1);
    chk("abort_total", bus.total_move_count, 0);
    rst = 1'b0;
    cnt_q.delete();
    dly_q.delete();
    held = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) held++;
    end
    chk("abort_no_done", held, 0);
    cnt_q = '{4, 6};
    dly_q = '{2, 1};
    do_run(2, 1'b0, lat, np);
    chk_stats(10, 2, 6, 4);
    chk("after_abort_pulses", np, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
